// File: rtl/axicb_pkg.sv
// Shared crossbar definitions: master-index type and the round-robin grant
// helpers used by both request arbiters of the slave-side switch.
package axicb_pkg;

    localparam int MST_NB_MAX = 8;
    localparam int MST_IDX_W  = (MST_NB_MAX > 1) ? $clog2(MST_NB_MAX) : 1;

    typedef logic [MST_IDX_W-1:0] mst_idx_t;

    typedef struct packed {
        logic     valid;
        mst_idx_t idx;
    } rr_grant_t;

    // First requester found scanning upward from ptr, wrapping modulo nb.
    function automatic rr_grant_t rr_arbitrate(input logic [MST_NB_MAX-1:0] req,
                                               input mst_idx_t              ptr,
                                               input int                    nb);
        rr_grant_t g;
        int        cand;
        g = '0;
        for (int i = MST_NB_MAX - 1; i >= 0; i--) begin
            cand = (int'(ptr) + i) % nb;
            if (i < nb && req[mst_idx_t'(cand)]) begin
                g.valid = 1'b1;
                g.idx   = mst_idx_t'(cand);
            end
        end
        return g;
    endfunction

    function automatic mst_idx_t rr_next_ptr(input mst_idx_t g, input int nb);
        return mst_idx_t'((int'(g) + 1) % nb);
    endfunction

endpackage

// File: rtl/axicb_mst_route_fifo.sv
// Small register FIFO of master indices; remembers which master owns each
// outstanding request so data and responses can be steered in order.
module axicb_mst_route_fifo
    import axicb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     aclk,
    input  logic     arst,
    input  logic     push_i,
    input  mst_idx_t idx_i,
    input  logic     pop_i,
    output logic     full_o,
    output logic     empty_o,
    output mst_idx_t head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mst_idx_t         mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge aclk) begin
        if (do_push) mem_q[wr_ptr_q] <= idx_i;
    end

endmodule

// File: rtl/axicb_mst_switch.sv
// Slave-side crossbar switch: round-robin AW/AR arbitration from MST_NB masters,
// with W steering and B/R return routing driven by in-order route FIFOs.
module axicb_mst_switch
    import axicb_pkg::*;
#(
    parameter int MST_NB     = 4,
    parameter int OSTDREQ_NB = 4,
    parameter int AWCH_W     = 8,
    parameter int WCH_W      = 8,
    parameter int BCH_W      = 8,
    parameter int ARCH_W     = 8,
    parameter int RCH_W      = 8
) (
    input  logic                     aclk,
    input  logic                     arst,
    input  logic [MST_NB-1:0]        i_awvalid,
    output logic [MST_NB-1:0]        i_awready,
    input  logic [MST_NB*AWCH_W-1:0] i_awch,
    input  logic [MST_NB-1:0]        i_wvalid,
    output logic [MST_NB-1:0]        i_wready,
    input  logic [MST_NB-1:0]        i_wlast,
    input  logic [MST_NB*WCH_W-1:0]  i_wch,
    output logic [MST_NB-1:0]        i_bvalid,
    input  logic [MST_NB-1:0]        i_bready,
    output logic [BCH_W-1:0]         i_bch,
    input  logic [MST_NB-1:0]        i_arvalid,
    output logic [MST_NB-1:0]        i_arready,
    input  logic [MST_NB*ARCH_W-1:0] i_arch,
    output logic [MST_NB-1:0]        i_rvalid,
    input  logic [MST_NB-1:0]        i_rready,
    output logic [MST_NB-1:0]        i_rlast,
    output logic [RCH_W-1:0]         i_rch,
    output logic                     o_awvalid,
    input  logic                     o_awready,
    output logic [AWCH_W-1:0]        o_awch,
    output logic                     o_wvalid,
    input  logic                     o_wready,
    output logic                     o_wlast,
    output logic [WCH_W-1:0]         o_wch,
    input  logic                     o_bvalid,
    output logic                     o_bready,
    input  logic [BCH_W-1:0]         o_bch,
    output logic                     o_arvalid,
    input  logic                     o_arready,
    output logic [ARCH_W-1:0]        o_arch,
    input  logic                     o_rvalid,
    output logic                     o_rready,
    input  logic                     o_rlast,
    input  logic [RCH_W-1:0]         o_rch
);

    logic [MST_NB_MAX-1:0] aw_req, ar_req;
    rr_grant_t             aw_rr, ar_rr;
    mst_idx_t              aw_sel, ar_sel;
    logic                  aw_any, ar_any, aw_hs, ar_hs;
    mst_idx_t              aw_ptr_q, aw_ptr_d, ar_ptr_q, ar_ptr_d;
    logic                  aw_lock_q, aw_lock_d, ar_lock_q, ar_lock_d;
    mst_idx_t              aw_lock_idx_q, ar_lock_idx_q;
    logic                  w_full, w_empty, b_full, b_empty, r_full, r_empty;
    mst_idx_t              w_head, b_head, r_head;

    // A stalled request keeps its grant so the slave sees a stable payload.
    always_comb begin
        aw_req              = '0;
        aw_req[MST_NB-1:0]  = i_awvalid;
        aw_rr               = rr_arbitrate(aw_req, aw_ptr_q, MST_NB);
        aw_sel              = aw_lock_q ? aw_lock_idx_q : aw_rr.idx;
        aw_any              = aw_lock_q ? aw_req[aw_lock_idx_q] : aw_rr.valid;
        o_awvalid           = aw_any & ~w_full & ~b_full & ~arst;
        aw_hs               = o_awvalid & o_awready;
        aw_lock_d           = o_awvalid & ~o_awready;
        aw_ptr_d            = aw_hs ? rr_next_ptr(aw_sel, MST_NB) : aw_ptr_q;

        ar_req              = '0;
        ar_req[MST_NB-1:0]  = i_arvalid;
        ar_rr               = rr_arbitrate(ar_req, ar_ptr_q, MST_NB);
        ar_sel              = ar_lock_q ? ar_lock_idx_q : ar_rr.idx;
        ar_any              = ar_lock_q ? ar_req[ar_lock_idx_q] : ar_rr.valid;
        o_arvalid           = ar_any & ~r_full & ~arst;
        ar_hs               = o_arvalid & o_arready;
        ar_lock_d           = o_arvalid & ~o_arready;
        ar_ptr_d            = ar_hs ? rr_next_ptr(ar_sel, MST_NB) : ar_ptr_q;
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            aw_ptr_q      <= '0;
            aw_lock_q     <= 1'b0;
            aw_lock_idx_q <= '0;
            ar_ptr_q      <= '0;
            ar_lock_q     <= 1'b0;
            ar_lock_idx_q <= '0;
        end else begin
            aw_ptr_q      <= aw_ptr_d;
            aw_lock_q     <= aw_lock_d;
            aw_lock_idx_q <= aw_sel;
            ar_ptr_q      <= ar_ptr_d;
            ar_lock_q     <= ar_lock_d;
            ar_lock_idx_q <= ar_sel;
        end
    end

    always_comb begin
        o_awch   = '0;
        o_arch   = '0;
        o_wch    = '0;
        o_wvalid = 1'b0;
        o_wlast  = 1'b0;
        o_bready = 1'b0;
        o_rready = 1'b0;
        for (int m = 0; m < MST_NB; m++) begin
            if (aw_sel == mst_idx_t'(m)) o_awch = i_awch[m*AWCH_W +: AWCH_W];
            if (ar_sel == mst_idx_t'(m)) o_arch = i_arch[m*ARCH_W +: ARCH_W];
            if (w_head == mst_idx_t'(m)) begin
                o_wch    = i_wch[m*WCH_W +: WCH_W];
                o_wvalid = ~w_empty & i_wvalid[m];
                o_wlast  = ~w_empty & i_wlast[m];
            end
            if (b_head == mst_idx_t'(m)) o_bready = ~b_empty & i_bready[m];
            if (r_head == mst_idx_t'(m)) o_rready = ~r_empty & i_rready[m];
        end
    end

    assign i_bch = o_bch;
    assign i_rch = o_rch;

    for (genvar gi = 0; gi < MST_NB; gi++) begin : g_mst
        assign i_awready[gi] = aw_hs & (aw_sel == mst_idx_t'(gi));
        assign i_arready[gi] = ar_hs & (ar_sel == mst_idx_t'(gi));
        assign i_wready[gi]  = ~w_empty & (w_head == mst_idx_t'(gi)) & o_wready;
        assign i_bvalid[gi]  = ~b_empty & (b_head == mst_idx_t'(gi)) & o_bvalid;
        assign i_rvalid[gi]  = ~r_empty & (r_head == mst_idx_t'(gi)) & o_rvalid;
        assign i_rlast[gi]   = ~r_empty & (r_head == mst_idx_t'(gi)) & o_rvalid & o_rlast;
    end

    axicb_mst_route_fifo #(.DEPTH(OSTDREQ_NB)) u_w_fifo (
        .aclk(aclk), .arst(arst), .push_i(aw_hs), .idx_i(aw_sel),
        .pop_i(o_wvalid & o_wready & o_wlast),
        .full_o(w_full), .empty_o(w_empty), .head_o(w_head)
    );

    axicb_mst_route_fifo #(.DEPTH(OSTDREQ_NB)) u_b_fifo (
        .aclk(aclk), .arst(arst), .push_i(aw_hs), .idx_i(aw_sel),
        .pop_i(o_bvalid & o_bready),
        .full_o(b_full), .empty_o(b_empty), .head_o(b_head)
    );

    axicb_mst_route_fifo #(.DEPTH(OSTDREQ_NB)) u_r_fifo (
        .aclk(aclk), .arst(arst), .push_i(ar_hs), .idx_i(ar_sel),
        .pop_i(o_rvalid & o_rready & o_rlast),
        .full_o(r_full), .empty_o(r_empty), .head_o(r_head)
    );

endmodule

// File: tb/tb_axicb_mst_switch.sv
// Directed bench for the slave-side switch: arbitration order, lock, W/B/R
// routing, FIFO-full back-pressure and asynchronous reset mid-burst.
module tb_axicb_mst_switch;

    logic        aclk;
    logic        arst;
    logic [3:0]  i_awvalid, i_awready;
    logic [31:0] i_awch;
    logic [3:0]  i_wvalid, i_wready, i_wlast;
    logic [31:0] i_wch;
    logic [3:0]  i_bvalid, i_bready;
    logic [7:0]  i_bch;
    logic [3:0]  i_arvalid, i_arready;
    logic [31:0] i_arch;
    logic [3:0]  i_rvalid, i_rready, i_rlast;
    logic [7:0]  i_rch;
    logic        o_awvalid, o_awready;
    logic [7:0]  o_awch;
    logic        o_wvalid, o_wready, o_wlast;
    logic [7:0]  o_wch;
    logic        o_bvalid, o_bready;
    logic [7:0]  o_bch;
    logic        o_arvalid, o_arready;
    logic [7:0]  o_arch;
    logic        o_rvalid, o_rready, o_rlast;
    logic [7:0]  o_rch;

    int total = 0;
    int bad   = 0;

    axicb_mst_switch dut (
        .aclk(aclk), .arst(arst),
        .i_awvalid(i_awvalid), .i_awready(i_awready), .i_awch(i_awch),
        .i_wvalid(i_wvalid), .i_wready(i_wready), .i_wlast(i_wlast), .i_wch(i_wch),
        .i_bvalid(i_bvalid), .i_bready(i_bready), .i_bch(i_bch),
        .i_arvalid(i_arvalid), .i_arready(i_arready), .i_arch(i_arch),
        .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rlast(i_rlast), .i_rch(i_rch),
        .o_awvalid(o_awvalid), .o_awready(o_awready), .o_awch(o_awch),
        .o_wvalid(o_wvalid), .o_wready(o_wready), .o_wlast(o_wlast), .o_wch(o_wch),
        .o_bvalid(o_bvalid), .o_bready(o_bready), .o_bch(o_bch),
        .o_arvalid(o_arvalid), .o_arready(o_arready), .o_arch(o_arch),
        .o_rvalid(o_rvalid), .o_rready(o_rready), .o_rlast(o_rlast), .o_rch(o_rch)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s val=%0h", tag, got);
        end
    endtask

    task automatic idle_inputs();
        i_awvalid = '0; i_wvalid = '0; i_wlast = '0; i_bready = '0;
        i_arvalid = '0; i_rready = '0; i_wch = '0;
        o_awready = 1'b0; o_wready = 1'b0; o_bvalid = 1'b0; o_bch = '0;
        o_arready = 1'b0; o_rvalid = 1'b0; o_rlast = 1'b0; o_rch = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        arst = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        arst = 1'b0;
        @(negedge aclk);
    endtask

    initial begin
        arst   = 1'b1;
        i_awch = {8'h43, 8'h42, 8'h41, 8'h10};
        i_arch = {8'h83, 8'h82, 8'h81, 8'h80};
        idle_inputs();
        @(negedge aclk);
        #1;
        check("rst_awvalid", 32'(o_awvalid), 32'd0);
        check("rst_wvalid",  32'(o_wvalid),  32'd0);
        check("rst_arvalid", 32'(o_arvalid), 32'd0);
        check("rst_bready",  32'(o_bready),  32'd0);
        check("rst_rready",  32'(o_rready),  32'd0);
        @(negedge aclk);
        arst = 1'b0;
        @(negedge aclk);

        // M0 single write: AW, 4 W beats, B; W offered before AW must stall
        i_wvalid = 4'b0001; i_wch = 32'hA0; o_wready = 1'b1;
        i_awvalid = 4'b0001; o_awready = 1'b1;
        #1;
        check("t1_awvalid",  32'(o_awvalid), 32'd1);
        check("t1_awch",     32'(o_awch),    32'h10);
        check("t1_awready",  32'(i_awready), 32'b0001);
        check("t1_w_stall",  32'(o_wvalid),  32'd0);
        check("t1_wready0",  32'(i_wready),  32'd0);
        @(negedge aclk);
        i_awvalid = '0;
        for (int b = 0; b < 4; b++) begin
            i_wch   = 32'(8'hA0 + b);
            i_wlast = (b == 3) ? 4'b0001 : 4'b0000;
            #1;
            check($sformatf("t1_wvalid%0d", b), 32'(o_wvalid), 32'd1);
            check($sformatf("t1_wch%0d", b),    32'(o_wch),    32'(8'hA0 + b));
            check($sformatf("t1_wlast%0d", b),  32'(o_wlast),  (b == 3) ? 32'd1 : 32'd0);
            check($sformatf("t1_wready%0d", b), 32'(i_wready), 32'b0001);
            @(negedge aclk);
        end
        i_wlast = '0;
        #1;
        check("t1_w_done", 32'(o_wvalid), 32'd0);
        i_wvalid = '0;
        o_bvalid = 1'b1; o_bch = 8'h00; i_bready = 4'b1111;
        #1;
        check("t1_bvalid", 32'(i_bvalid), 32'b0001);
        check("t1_bready", 32'(o_bready), 32'd1);
        check("t1_bch",    32'(i_bch),    32'h00);
        @(negedge aclk);
        #1;
        check("t1_b_spur_v", 32'(i_bvalid), 32'd0);
        check("t1_b_spur_r", 32'(o_bready), 32'd0);

        // M0 and M2 contend: 0,2,0,2 then FIFOs full; after one W+B pop pointer is 3
        do_reset();
        i_awvalid = 4'b0101; o_awready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("t2_grant%0d", c), 32'(i_awready), (c % 2 == 0) ? 32'b0001 : 32'b0100);
            check($sformatf("t2_awch%0d", c),  32'(o_awch),    (c % 2 == 0) ? 32'h10 : 32'h42);
            @(negedge aclk);
        end
        #1;
        check("t2_full_v", 32'(o_awvalid), 32'd0);
        check("t2_full_r", 32'(i_awready), 32'd0);
        i_awvalid = '0;
        i_wvalid = 4'b0001; i_wlast = 4'b0001; o_wready = 1'b1;
        o_bvalid = 1'b1; i_bready = 4'b1111;
        #1;
        check("t2_wpop", 32'(i_wready), 32'b0001);
        check("t2_bpop", 32'(i_bvalid), 32'b0001);
        @(negedge aclk);
        idle_inputs();
        i_awvalid = 4'b1111; o_awready = 1'b1;
        #1;
        check("t2_ptr3", 32'(i_awready), 32'b1000);
        check("t2_awch3", 32'(o_awch), 32'h43);
        @(negedge aclk);

        // Lock: stalled M0 keeps its grant while other masters arrive
        do_reset();
        i_awvalid = 4'b0001; o_awready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) i_awvalid = 4'b0011;
            #1;
            check($sformatf("t3_hold_ch%0d", c), 32'(o_awch), 32'h10);
            check($sformatf("t3_hold_rd%0d", c), 32'(i_awready), 32'd0);
            @(negedge aclk);
        end
        o_awready = 1'b1;
        #1;
        check("t3_m0_hs", 32'(i_awready), 32'b0001);
        @(negedge aclk);
        i_awvalid = 4'b0010;
        #1;
        check("t3_m1_hs", 32'(i_awready), 32'b0010);
        check("t3_m1_ch", 32'(o_awch),    32'h41);
        @(negedge aclk);
        i_awvalid = 4'b0001; o_awready = 1'b0;
        #1;
        check("t3_m0_again", 32'(o_awch), 32'h10);
        @(negedge aclk);
        i_awvalid = 4'b1001;
        #1;
        check("t3_lock_ch", 32'(o_awch), 32'h10);
        o_awready = 1'b1;
        #1;
        check("t3_lock_hs", 32'(i_awready), 32'b0001);
        @(negedge aclk);

        // Outstanding limit: 4 AWs fill the route FIFOs; B pop frees a slot a cycle later
        do_reset();
        i_awvalid = 4'b0001; o_awready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("t4_aw%0d", c), 32'(i_awready), 32'b0001);
            @(negedge aclk);
        end
        #1;
        check("t4_blk_v", 32'(o_awvalid), 32'd0);
        check("t4_blk_r", 32'(i_awready), 32'd0);
        @(negedge aclk);
        i_wvalid = 4'b0001; i_wlast = 4'b0001; o_wready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("t4_w%0d", c),    32'(i_wready),  32'b0001);
            check($sformatf("t4_bfull%0d", c), 32'(o_awvalid), 32'd0);
            @(negedge aclk);
        end
        i_wvalid = '0; i_wlast = '0;
        o_bvalid = 1'b1; i_bready = 4'b0001;
        #1;
        check("t4_b_hs",    32'(i_bvalid),  32'b0001);
        check("t4_popfull", 32'(o_awvalid), 32'd0);
        @(negedge aclk);
        o_bvalid = 1'b0;
        #1;
        check("t4_5th_v", 32'(o_awvalid), 32'd1);
        check("t4_5th_r", 32'(i_awready), 32'b0001);
        @(negedge aclk);

        // Reads: AR from M1 then M3, 2-beat bursts routed back in order
        do_reset();
        i_arvalid = 4'b1010; o_arready = 1'b1;
        #1;
        check("t5_ar1", 32'(i_arready), 32'b0010);
        check("t5_arch1", 32'(o_arch), 32'h81);
        @(negedge aclk);
        i_arvalid = 4'b1000;
        #1;
        check("t5_ar3", 32'(i_arready), 32'b1000);
        check("t5_arch3", 32'(o_arch), 32'h83);
        @(negedge aclk);
        i_arvalid = '0;
        o_rvalid = 1'b1; i_rready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] mask;
            mask    = (k < 2) ? 4'b0010 : 4'b1000;
            o_rlast = (k % 2 == 1);
            o_rch   = 8'(8'hC0 + k);
            #1;
            check($sformatf("t5_rvalid%0d", k), 32'(i_rvalid), 32'(mask));
            check($sformatf("t5_rlast%0d", k),  32'(i_rlast),  (k % 2 == 1) ? 32'(mask) : 32'd0);
            check($sformatf("t5_rch%0d", k),    32'(i_rch),    32'(8'hC0 + k));
            check($sformatf("t5_rready%0d", k), 32'(o_rready), 32'd1);
            @(negedge aclk);
        end
        #1;
        check("t5_r_empty_v", 32'(i_rvalid), 32'd0);
        check("t5_r_empty_r", 32'(o_rready), 32'd0);

        // Async reset during beat 2 of a write
        do_reset();
        i_awvalid = 4'b0001; o_awready = 1'b1;
        @(negedge aclk);
        i_awvalid = '0;
        i_wvalid = 4'b0001; o_wready = 1'b1; i_wch = 32'hB0;
        #1;
        check("t6_beat1", 32'(o_wvalid), 32'd1);
        @(negedge aclk);
        i_wch = 32'hB1;
        i_awvalid = 4'b0001; o_bvalid = 1'b1; i_bready = 4'b1111;
        arst = 1'b1;
        #1;
        check("t6_rst_wvalid",  32'(o_wvalid),  32'd0);
        check("t6_rst_wready",  32'(i_wready),  32'd0);
        check("t6_rst_awvalid", 32'(o_awvalid), 32'd0);
        check("t6_rst_awready", 32'(i_awready), 32'd0);
        check("t6_rst_bvalid",  32'(i_bvalid),  32'd0);
        check("t6_rst_bready",  32'(o_bready),  32'd0);
        @(negedge aclk);
        arst = 1'b0;
        i_awvalid = '0;
        #1;
        check("t6_w_empty", 32'(o_wvalid), 32'd0);
        check("t6_b_empty", 32'(o_bready), 32'd0);
        i_wvalid = '0; o_bvalid = 1'b0;
        i_awvalid = 4'b0101; o_awready = 1'b1;
        i_arvalid = 4'b0101; o_arready = 1'b1;
        #1;
        check("t6_awptr0", 32'(i_awready), 32'b0001);
        check("t6_arptr0", 32'(i_arready), 32'b0001);
        @(negedge aclk);
        idle_inputs();
        @(negedge aclk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
